// File: rtl/port_arbiter.sv
// Round-robin arbiter granting one ingress port at a time write permission,
// then streaming that port's stored packet out as buffer read beats.
module port_arbiter #(
  parameter int unsigned pPORTS      = 4,
  parameter int unsigned pFIFO_WIDTH = 11,
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDEPTH_RAM  = 3072,
  parameter int unsigned pTIMEOUT    = 255
) (
  input  logic                            iclk,
  input  logic                            i_rst,
  input  logic [pPORTS-1:0]               i_pkt_avail,
  input  logic [pPORTS-1:0]               i_request,
  input  logic [pPORTS*pFIFO_WIDTH-1:0]   i_length,
  input  logic [pPORTS*pADDR_WIDTH-1:0]   i_start_addr,
  input  logic                            i_out_ready,
  output logic [pPORTS-1:0]               o_permition,
  output logic                            o_rd_en,
  output logic [pADDR_WIDTH-1:0]          o_rd_addr,
  output logic [1:0]                      o_rd_port,
  output logic                            o_rd_last,
  output logic                            o_busy,
  output logic                            o_timeout
);

  localparam int unsigned PW = (pPORTS > 1) ? $clog2(pPORTS) : 1;
  localparam int unsigned TW = $clog2(pTIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_REQ, READ} state_t;

  state_t                  state;
  logic [PW-1:0]           cur;
  logic [PW-1:0]           rr_ptr;
  logic [TW-1:0]           tcnt;
  logic [pFIFO_WIDTH-1:0]  cnt;

  logic [pFIFO_WIDTH-1:0]  len_arr  [pPORTS];
  logic [pADDR_WIDTH-1:0]  addr_arr [pPORTS];

  for (genvar g = 0; g < int'(pPORTS); g++) begin : g_unpack
    assign len_arr[g]  = i_length[g*pFIFO_WIDTH +: pFIFO_WIDTH];
    assign addr_arr[g] = i_start_addr[g*pADDR_WIDTH +: pADDR_WIDTH];
  end

  // First port with a stored packet, searching upward from rr_ptr with wrap
  logic [PW-1:0] sel_c;
  logic          any_c;
  always_comb begin
    int idx;
    idx   = 0;
    sel_c = rr_ptr;
    any_c = 1'b0;
    for (int i = 0; i < int'(pPORTS); i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= int'(pPORTS)) idx = idx - int'(pPORTS);
      if (!any_c && i_pkt_avail[PW'(idx)]) begin
        sel_c = PW'(idx);
        any_c = 1'b1;
      end
    end
  end

  logic [PW-1:0]          nxt_port_c;
  logic [pADDR_WIDTH-1:0] addr_inc_c;
  assign nxt_port_c = (cur == PW'(pPORTS - 1)) ? '0 : cur + 1'b1;
  assign addr_inc_c = (o_rd_addr == pADDR_WIDTH'(pDEPTH_RAM - 1)) ? '0 : o_rd_addr + 1'b1;

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cur         <= '0;
      rr_ptr      <= '0;
      tcnt        <= '0;
      cnt         <= '0;
      o_permition <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_port   <= '0;
      o_rd_last   <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_permition <= '0;
      o_timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_c) begin
            state       <= GRANT;
            cur         <= sel_c;
            o_rd_port   <= 2'(sel_c);
            o_permition <= pPORTS'(1) << sel_c;
            o_busy      <= 1'b1;
          end
        end
        GRANT: begin
          tcnt  <= '0;
          state <= WAIT_REQ;
        end
        WAIT_REQ: begin
          // A request on the terminal-count cycle wins over the timeout
          if (i_request[cur]) begin
            if (len_arr[cur] == '0) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              rr_ptr <= nxt_port_c;
            end else begin
              state     <= READ;
              cnt       <= len_arr[cur];
              o_rd_addr <= addr_arr[cur];
              o_rd_en   <= 1'b1;
              o_rd_last <= (len_arr[cur] == pFIFO_WIDTH'(1));
            end
          end else if (tcnt == TW'(pTIMEOUT - 1)) begin
            state     <= IDLE;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            rr_ptr    <= nxt_port_c;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        READ: begin
          if (i_out_ready) begin
            if (cnt == pFIFO_WIDTH'(1)) begin
              state     <= IDLE;
              o_rd_en   <= 1'b0;
              o_rd_last <= 1'b0;
              o_busy    <= 1'b0;
              rr_ptr    <= nxt_port_c;
            end else begin
              o_rd_addr <= addr_inc_c;
              cnt       <= cnt - 1'b1;
              o_rd_last <= (cnt == pFIFO_WIDTH'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: grant order, read beats, wrap, timeout,
// backpressure, zero length and asynchronous reset during a transfer.
module tb_port_arbiter;

  localparam int P     = 4;
  localparam int FW    = 11;
  localparam int AW    = 12;
  localparam int DEPTH = 3072;

  logic              iclk = 1'b0;
  logic              i_rst;
  logic [P-1:0]      i_pkt_avail;
  logic [P-1:0]      i_request;
  logic [P*FW-1:0]   i_length;
  logic [P*AW-1:0]   i_start_addr;
  logic              i_out_ready;
  logic [P-1:0]      o_permition;
  logic              o_rd_en;
  logic [AW-1:0]     o_rd_addr;
  logic [1:0]        o_rd_port;
  logic              o_rd_last;
  logic              o_busy;
  logic              o_timeout;

  int n_total = 0;
  int n_bad   = 0;

  port_arbiter dut (
    .iclk         (iclk),
    .i_rst        (i_rst),
    .i_pkt_avail  (i_pkt_avail),
    .i_request    (i_request),
    .i_length     (i_length),
    .i_start_addr (i_start_addr),
    .i_out_ready  (i_out_ready),
    .o_permition  (o_permition),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .o_rd_port    (o_rd_port),
    .o_rd_last    (o_rd_last),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap_inc(input int a);
    return (a == DEPTH - 1) ? 0 : a + 1;
  endfunction

  task automatic tick();
    @(negedge iclk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_perm"},    32'(o_permition), 32'(0));
    chk({tag, "_rd_en"},   32'(o_rd_en),     32'(0));
    chk({tag, "_rd_addr"}, 32'(o_rd_addr),   32'(0));
    chk({tag, "_rd_port"}, 32'(o_rd_port),   32'(0));
    chk({tag, "_rd_last"}, 32'(o_rd_last),   32'(0));
    chk({tag, "_busy"},    32'(o_busy),      32'(0));
    chk({tag, "_timeout"}, 32'(o_timeout),   32'(0));
  endtask

  // Entered at an IDLE-state negedge with i_pkt_avail already driven
  task automatic wait_grant(input int port);
    int k;
    for (k = 0; k < 20 && o_permition == '0; k++) tick();
    chk("grant_latency", 32'(k),           32'(1));
    chk("grant_onehot",  32'(o_permition), 32'(1 << port));
    chk("grant_busy",    32'(o_busy),      32'(1));
    chk("grant_port",    32'(o_rd_port),   32'(port));
  endtask

  task automatic run_pkt(input int port, input int len, input int addr, input int dly, input bit bp);
    int a, rem, k;
    bit rdy;
    wait_grant(port);
    tick();
    chk("perm_one_cycle", 32'(o_permition), 32'(0));
    repeat (dly) tick();
    i_request = P'(1 << port);
    i_length[port*FW +: FW]     = FW'(len);
    i_start_addr[port*AW +: AW] = AW'(addr);
    tick();
    i_request = '0;
    chk("timeout_quiet", 32'(o_timeout), 32'(0));
    if (len == 0) begin
      chk("zero_len_rd_en", 32'(o_rd_en), 32'(0));
      chk("zero_len_busy",  32'(o_busy),  32'(0));
    end else begin
      a = addr;
      rem = len;
      k = 0;
      while (rem > 0 && k < 100) begin
        chk("beat_rd_en",   32'(o_rd_en),   32'(1));
        chk("beat_rd_addr", 32'(o_rd_addr), 32'(a));
        chk("beat_rd_last", 32'(o_rd_last), 32'(rem == 1));
        chk("beat_rd_port", 32'(o_rd_port), 32'(port));
        rdy = bp ? (k % 2 == 0) : 1'b1;
        i_out_ready = rdy;
        tick();
        k++;
        if (rdy) begin
          a = wrap_inc(a);
          rem--;
        end
      end
      i_out_ready = 1'b1;
      chk("beats_done", 32'(rem),    32'(0));
      chk("end_rd_en",  32'(o_rd_en), 32'(0));
      chk("end_busy",   32'(o_busy),  32'(0));
    end
  endtask

  initial begin
    int k;
    i_rst        = 1'b1;
    i_pkt_avail  = '0;
    i_request    = '0;
    i_length     = '0;
    i_start_addr = '0;
    i_out_ready  = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    i_rst = 1'b0;

    // Single packet on port 0: addresses 10..13, last on 13
    i_pkt_avail = 4'b0001;
    run_pkt(0, 4, 10, 0, 1'b0);
    i_pkt_avail = 4'b0000;
    tick();
    chk("single_stays_idle", 32'(o_busy), 32'(0));

    // Round robin from a fresh reset with every port holding packets
    do_reset();
    i_pkt_avail = 4'b1111;
    run_pkt(0, 1, 40, 0, 1'b0);
    run_pkt(1, 1, 41, 0, 1'b0);
    run_pkt(2, 1, 42, 0, 1'b0);
    run_pkt(3, 1, 43, 0, 1'b0);
    run_pkt(0, 1, 44, 0, 1'b0);

    // Timeout on port 2; a foreign request on port 0 must be ignored
    i_pkt_avail = 4'b1100;
    wait_grant(2);
    tick();
    for (k = 1; k <= 300; k++) begin
      if (k == 10) begin
        i_request = 4'b0001;
        i_length[0 +: FW] = FW'(5);
      end else begin
        i_request = '0;
      end
      tick();
      if (o_timeout === 1'b1) break;
    end
    i_request = '0;
    chk("timeout_cycles", 32'(k),       32'(255));
    chk("timeout_busy",   32'(o_busy),  32'(0));
    chk("timeout_rd_en",  32'(o_rd_en), 32'(0));
    tick();
    chk("timeout_pulse",  32'(o_timeout),   32'(0));
    chk("after_timeout_p3", 32'(o_permition), 32'(4'b1000));
    i_pkt_avail = '0;

    // Zero-length request on port 3
    tick();
    i_request = 4'b1000;
    i_length[3*FW +: FW] = '0;
    tick();
    i_request = '0;
    chk("zero_len_rd_en", 32'(o_rd_en), 32'(0));
    chk("zero_len_busy",  32'(o_busy),  32'(0));
    tick();
    chk("zero_len_no_beat", 32'(o_rd_en), 32'(0));

    // Request on the terminal-count cycle is accepted
    i_pkt_avail = 4'b0001;
    run_pkt(0, 2, 100, 254, 1'b0);

    // Backpressure with ready toggling 1,0,1,0
    i_pkt_avail = 4'b0010;
    run_pkt(1, 3, 200, 0, 1'b1);

    // Address wrap 3070,3071,0,1
    i_pkt_avail = 4'b0100;
    run_pkt(2, 4, 3070, 0, 1'b0);

    // Reset after the second beat of a 6-beat packet
    i_pkt_avail = 4'b0001;
    wait_grant(0);
    i_pkt_avail = '0;
    tick();
    i_request = 4'b0001;
    i_length[0 +: FW]     = FW'(6);
    i_start_addr[0 +: AW] = AW'(500);
    tick();
    i_request = '0;
    chk("mid_beat1", 32'(o_rd_addr), 32'(500));
    tick();
    chk("mid_beat2", 32'(o_rd_addr), 32'(501));
    tick();
    chk("mid_beat3", 32'(o_rd_addr), 32'(502));
    chk("mid_beat3_en", 32'(o_rd_en), 32'(1));
    #2 i_rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    tick();
    tick();
    i_rst = 1'b0;
    i_pkt_avail = 4'b1001;
    wait_grant(0);
    i_pkt_avail = '0;
    tick();
    tick();
    chk("post_rst_no_resume", 32'(o_rd_en), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
